// File: rtl/univ_shift_reg_if.sv
// Bus bundle for the universal shift register: control/data in, contents and status out.
// The master drives the controls; the slave is the register itself.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] Din;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] Dout;
    logic             sout_l;
    logic             sout_r;
    logic [CNT_W-1:0] cnt;
    logic             done;

    modport master (
        output en, mode, Din, sin_l, sin_r,
        input  Dout, sout_l, sout_r, cnt, done
    );

    modport slave (
        input  en, mode, Din, sin_l, sin_r,
        output Dout, sout_l, sout_r, cnt, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shift, rotate and clear, plus a saturating count of
// shift/rotate steps since the last load or clear.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    univ_shift_reg_if.slave   bus
);
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        if (bus.en) begin
            case (bus.mode)
                MODE_LOAD: begin
                    dout_d = bus.Din;
                    cnt_d  = '0;
                end
                MODE_SHL: begin
                    dout_d = {dout_q[WIDTH-2:0], bus.sin_r};
                    cnt_d  = cnt_inc;
                end
                MODE_SHR: begin
                    dout_d = {bus.sin_l, dout_q[WIDTH-1:1]};
                    cnt_d  = cnt_inc;
                end
                MODE_ROTL: begin
                    dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                    cnt_d  = cnt_inc;
                end
                MODE_ROTR: begin
                    dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
                    cnt_d  = cnt_inc;
                end
                MODE_CLEAR: begin
                    dout_d = '0;
                    cnt_d  = '0;
                end
                // hold and the reserved code 111 keep everything as is
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
            cnt_q  <= '0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.Dout   = dout_q;
    assign bus.sout_l = dout_q[WIDTH-1];
    assign bus.sout_r = dout_q[0];
    assign bus.cnt    = cnt_q;
    assign bus.done   = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8 with hand-computed expectations.
module tb_univ_shift_reg;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010,
                           M_SHR = 3'b011, M_ROTL = 3'b100, M_ROTR = 3'b101,
                           M_CLR = 3'b110, M_RSV = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-18s got=0x%0h", tag, got);
        end else begin
            $display("FAIL %-18s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, return 1ns after it.
    task automatic op(input logic e, input logic [2:0] m, input logic [7:0] d,
                      input logic sl, input logic sr);
        bus.en    = e;
        bus.mode  = m;
        bus.Din   = d;
        bus.sin_l = sl;
        bus.sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] d, input logic [3:0] c);
        check({tag, ".dout"}, bus.Dout, d);
        check({tag, ".cnt"},  bus.cnt,  c);
        check({tag, ".done"}, bus.done, (c == 4'd8));
    endtask

    logic [7:0] ser_exp;

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = M_HOLD; bus.Din = '0; bus.sin_l = 1'b0; bus.sin_r = 1'b0;
        @(posedge clk); #1;
        op(1'b1, M_LOAD, 8'hFF, 1'b1, 1'b1);
        check_state("reset", 8'h00, 4'd0);
        check("reset.sout_l", bus.sout_l, 1'b0);
        check("reset.sout_r", bus.sout_r, 1'b0);
        rst_n = 1'b1;

        op(1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0);
        check_state("load_a5", 8'hA5, 4'd0);
        op(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
        check_state("shl_a5", 8'h4B, 4'd1);
        op(1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0);
        check_state("reload_a5", 8'hA5, 4'd0);
        op(1'b1, M_SHR, 8'h00, 1'b0, 1'b1);
        check_state("shr_a5", 8'h52, 4'd1);

        op(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        op(1'b1, M_ROTL, 8'hFF, 1'b0, 1'b0);
        check_state("rotl_81", 8'h03, 4'd1);
        check("rotl.sout_l", bus.sout_l, 1'b0);
        check("rotl.sout_r", bus.sout_r, 1'b1);
        op(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        op(1'b1, M_ROTR, 8'h00, 1'b0, 1'b0);
        check_state("rotr_81", 8'hC0, 4'd1);
        op(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) op(1'b1, M_ROTL, 8'h00, 1'b1, 1'b1);
        check_state("rotl7_81", 8'hC0, 4'd7);
        op(1'b1, M_ROTL, 8'h00, 1'b1, 1'b1);
        check_state("rotl8_81", 8'h81, 4'd8);

        op(1'b1, M_LOAD, 8'hC3, 1'b0, 1'b0);
        ser_exp = 8'b1100_0011;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ser_bit%0d", i), bus.sout_l, ser_exp[7-i]);
            op(1'b1, M_SHL, 8'hFF, 1'b1, 1'b0);
        end
        check_state("ser_end", 8'h00, 4'd8);
        op(1'b1, M_SHL, 8'hFF, 1'b1, 1'b0);
        check_state("ser_sat", 8'h00, 4'd8);
        op(1'b1, M_SHR, 8'h00, 1'b1, 1'b0);
        check_state("sat_shr", 8'h80, 4'd8);

        op(1'b1, M_CLR, 8'hFF, 1'b1, 1'b1);
        check_state("clear", 8'h00, 4'd0);
        op(1'b1, M_RSV, 8'hFF, 1'b1, 1'b1);
        check_state("rsv_after_clr", 8'h00, 4'd0);
        op(1'b1, M_LOAD, 8'h5A, 1'b0, 1'b0);
        op(1'b1, M_SHL, 8'h00, 1'b1, 1'b0);
        check_state("shl_5a", 8'hB4, 4'd1);
        op(1'b1, M_RSV, 8'hFF, 1'b1, 1'b1);
        check_state("reserved", 8'hB4, 4'd1);
        op(1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1);
        check_state("hold", 8'hB4, 4'd1);

        op(1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0);
        op(1'b0, M_SHL,  8'hFF, 1'b1, 1'b1); check_state("en0_shl",  8'h3C, 4'd0);
        op(1'b0, M_CLR,  8'hFF, 1'b1, 1'b1); check_state("en0_clr",  8'h3C, 4'd0);
        op(1'b0, M_LOAD, 8'hFF, 1'b1, 1'b1); check_state("en0_load", 8'h3C, 4'd0);
        op(1'b0, M_SHR,  8'hFF, 1'b1, 1'b1); check_state("en0_shr",  8'h3C, 4'd0);
        op(1'b0, M_ROTL, 8'hFF, 1'b1, 1'b1); check_state("en0_rotl", 8'h3C, 4'd0);

        op(1'b1, M_LOAD, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) op(1'b1, M_SHL, 8'h00, 1'b0, 1'b0);
        check_state("shl3_0f", 8'h78, 4'd3);
        rst_n = 1'b0;
        op(1'b1, M_LOAD, 8'hFF, 1'b1, 1'b1);
        check_state("rst_prio", 8'h00, 4'd0);
        rst_n = 1'b1;
        op(1'b1, M_LOAD, 8'h5A, 1'b0, 1'b0);
        check_state("resume", 8'h5A, 4'd0);
        op(1'b1, M_ROTR, 8'h00, 1'b0, 1'b0);
        check_state("rotr_5a", 8'h2D, 4'd1);
        bus.en = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_state("rst_low_no_edge", 8'h2D, 4'd1);
        #1 rst_n = 1'b1;
        #1 check_state("rst_glitch", 8'h2D, 4'd1);
        op(1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1);
        check_state("after_glitch", 8'h2D, 4'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8; register width in bits; legal range 2..64.
REQ-002 Parameter: CNT_W, default $clog2(WIDTH+1); shift-counter width, derived, not overridden.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: en  input  1  operation enable; low = hold all state.
REQ-006 Port: mode  input  3  operation select, decoded per REQ-011.
REQ-007 Port: Din  input  WIDTH  parallel load data.
REQ-008 Port: sin_l / sin_r  input  1 each  serial-in bits: sin_l enters at MSB on right shift; sin_r enters at LSB on left shift.
REQ-009 Port: Dout  output  WIDTH  registered contents.
REQ-010 Port: sout_l / sout_r  output  1 each  Dout[WIDTH-1] / Dout[0], combinational from Dout; cnt  output  CNT_W  shift count; done  output  1  cnt==WIDTH.

Function
REQ-011 Mode decode, only when en=1:
- 000 hold
- 001 load: Dout<=Din
- 010 shl: Dout<={Dout[W-2:0],sin_r}
- 011 shr: Dout<={sin_l,Dout[W-1:1]}
- 100 rotl: Dout<={Dout[W-2:0],Dout[W-1]}
- 101 rotr: Dout<={Dout[0],Dout[W-1:1]}
- 110 clear: Dout<=0
- 111 reserved: behaves as hold
REQ-012 Latency: Dout reflects the operation one clk edge after en/mode/Din sampled; no combinational path from inputs to Dout, cnt or done.
REQ-013 en=0: Dout and cnt hold regardless of mode, Din and serial inputs.
REQ-014 Counter: load or clear (en=1) sets cnt=0 on the same edge.
REQ-015 Counter: each shl/shr/rotl/rotr with en=1 increments cnt by 1, saturating at WIDTH.
REQ-016 Counter: hold and reserved modes leave cnt unchanged.
REQ-017 done = (cnt==WIDTH), decoded from the cnt register; stays high until the next load, clear or reset.
REQ-018 Saturation: shifts/rotates at cnt==WIDTH still update Dout; cnt stays WIDTH.
REQ-019 Rotation conserves population count; a WIDTH-step rotl or rotr returns Dout to its starting value.
REQ-020 Serial inputs are sampled only in shl/shr and ignored in every other mode.

Reset
REQ-021 rst_n=0 at a rising edge sets Dout=0 and cnt=0, which forces done=0, sout_l=0 and sout_r=0.
REQ-022 Reset has priority over en and every mode, including mid-sequence shifts.
REQ-023 Reset has no asynchronous effect: state is unchanged between edges while rst_n is low.
REQ-024 Operation resumes on the first edge with rst_n=1.

Verification (WIDTH=8)
REQ-025 Load/shift: load 0xA5, then shl with sin_r=1 -> Dout=0x4B, cnt=1; load 0xA5, then shr with sin_l=0 -> Dout=0x52, cnt=1.
REQ-026 Rotate: load 0x81, rotl -> 0x03, sout_l=0, sout_r=1; load 0x81, rotr -> 0xC0; 8 rotl from 0x81 -> 0x81, done=1.
REQ-027 Serializer: load 0xC3, then 8 shl with sin_r=0 -> sout_l sequence 1,1,0,0,0,0,1,1 sampled before each edge; then Dout=0x00, cnt=8, done=1; a 9th shl leaves cnt=8.
REQ-028 Enable gating: load 0x3C, then en=0 with mode=shl/clear/load (Din=0xFF) for 5 cycles -> Dout=0x3C, cnt=0 throughout.
REQ-029 Reset priority: after 3 shifts (cnt=3), rst_n=0 with en=1, mode=load, Din=0xFF -> next edge Dout=0x00, cnt=0; rst_n toggled low then high between edges with no edge -> no change.
REQ-030 Clear/reserved: from cnt=8, clear -> Dout=0, cnt=0, done=0; mode=111 with Din=0xFF -> no change.
